dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter that shares the single-port data RAM (`dm_we`/`dm_re`/`dm_ad`/`dm_d`/`dm_q`) between the MIPS core and a DMA/loader master.
- Sits between the `MIPS` data-memory port, the DMA master and `ram`.
- Serialises accesses with a req/gnt handshake and returns read data with a valid strobe.
- Arbitration is round-robin; a parameter switches it to fixed core priority.

Parameters:
- N, 32, data width (from the_pkg)
- dmAddB, the_pkg value, data-memory address width
- CORE_PRIO, 0, 1 = core always wins ties; 0 = round-robin

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- c_req  in  1  core access request; held until c_gnt
- c_we  in  1  core: 1 = write, 0 = read; stable while c_req
- c_ad  in  dmAddB  core word address
- c_d  in  N  core write data
- c_gnt  out  1  one-cycle grant pulse to core
- c_rvalid  out  1  one-cycle core read-data valid
- c_q  out  N  core read data
- d_req, d_we, d_ad, d_d  in  1/1/dmAddB/N  DMA request, same rules as core
- d_gnt, d_rvalid, d_q  out  1/1/N  DMA grant, read valid, read data
- dm_we  out  1  RAM write enable
- dm_re  out  1  RAM read enable
- dm_ad  out  dmAddB  RAM address
- dm_d  out  N  RAM write data
- dm_q  in  N  RAM read data; valid the cycle after the dm_re cycle

Behaviour:
- The block has one clock (clk). Reset rst_n is asynchronous and active-low.
- All outputs are registered. The RAM read latency is 1 cycle: dm_q is valid the cycle after the cycle in which dm_re is high.
- Reset values: all outputs 0, state IDLE, rr_ptr = 0 (core next). Reset mid-transaction aborts it; no gnt/rvalid is issued afterwards.
- FSM states: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Samples c_req/d_req at each edge. With none, stays in IDLE.
  - Winner selection: only one requesting -> it wins. Both requesting -> CORE_PRIO = 1 gives core; else the requester pointed to by rr_ptr.
  - On a winner: latch its we/ad/d, set sel, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive dm_ad/dm_d from the latch; dm_we = latched we, dm_re = ~latched we.
  - Pulse the winner's gnt this same cycle.
  - rr_ptr toggles to the loser, only when both requested at selection.
  - Write -> IDLE. Read -> RD_WAIT.
- RD_WAIT (1 cycle):
  - dm_we = dm_re = 0.
  - Register dm_q into the selected requester's q.
  - Pulse its rvalid in the next cycle (the IDLE cycle).
- Latency: req sampled at edge E -> gnt in cycle E+1 -> read rvalid in cycle E+3.
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per 3 cycles.
  - Back-to-back grants alternate between requesters when both are continuously requesting (CORE_PRIO = 0).
- Requester rules:
  - Must hold req, we, ad, d stable until it sees gnt.
  - Must deassert req in the cycle after gnt, or present a new request.
  - A req deasserted before gnt is simply not served. The arbiter ignores req outside IDLE.
- c_q/d_q hold their last value between rvalids. The non-selected requester's q/rvalid are untouched.
- dm_ad/dm_d hold their last value when idle. dm_we/dm_re are 0 in every cycle except ISSUE.
- Writes never assert dm_re. Reads never assert dm_we. Never are both high together.

Decomposition:
- the_pkg: N and dmAddB (already present); add the arb_state_t enum {IDLE, ISSUE, RD_WAIT} and the requester-select typedef.
- Natural sub-module: dm_arb_pick, a combinational winner selection taking c_req, d_req, rr_ptr and CORE_PRIO, returning grant_valid and sel.
- The FSM, latches and output registers stay in dm_arbiter.

Test Plan:
- Core write alone: c_req = 1, c_we = 1, c_ad = 10, c_d = 11.
  - c_gnt pulses 1 cycle after the sampling edge.
  - In the same cycle dm_we = 1, dm_ad = 10, dm_d = 11.
  - ram.memoria[10] = 11 afterwards; d_gnt never pulses.
- DMA read alone: d_req = 1, d_we = 0, d_ad = 22 with memoria[22] = 22.
  - d_gnt, then dm_re = 1 for exactly 1 cycle.
  - d_rvalid pulses 2 cycles after d_gnt with d_q = 22; c_rvalid stays 0.
- Simultaneous continuous requests, CORE_PRIO = 0, both writing (core ad = 1, DMA ad = 2).
  - Grants alternate core, DMA, core, DMA.
  - 4 grants within 8 cycles.
- Same as above with CORE_PRIO = 1.
  - Core held requesting gets every grant.
  - DMA is granted only after c_req drops.
- Reset mid-read: assert rst_n = 0 asynchronously while in RD_WAIT.
  - All outputs go to 0 immediately, without waiting for an edge.
  - No rvalid after release; the next request is served normally.
- Read-after-write, same address: core writes 0xA5 to address 5, then reads address 5.
  - c_q = 0xA5 with c_rvalid.
  - dm_we and dm_re are never high in the same cycle throughout.

Source files
------------

// File: rtl/the_pkg.sv
// Shared widths and types for the data-memory path between the MIPS core, the DMA master and ram.
package the_pkg;
  localparam int N      = 32;
  localparam int dmAddB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    SEL_CORE = 1'b0,
    SEL_DMA  = 1'b1
  } req_sel_t;
endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection between the core and DMA requesters.
module dm_arb_pick
  import the_pkg::*;
#(
  parameter bit CORE_PRIO = 1'b0
) (
  input  logic     c_req,
  input  logic     d_req,
  input  req_sel_t rr_ptr,
  output logic     grant_valid,
  output logic     both,
  output req_sel_t sel
);

  always_comb begin
    grant_valid = c_req | d_req;
    both        = c_req & d_req;
    sel         = SEL_CORE;
    if (both) begin
      sel = CORE_PRIO ? SEL_CORE : rr_ptr;
    end else if (d_req) begin
      sel = SEL_DMA;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data RAM between the MIPS core and the DMA/loader master.
// Handshake: a requester holds req/we/ad/d stable until it sees its one-cycle gnt; req is only
// sampled in IDLE, and read data returns with a one-cycle rvalid two cycles after gnt.
module dm_arbiter #(
  parameter int N         = the_pkg::N,
  parameter int dmAddB    = the_pkg::dmAddB,
  parameter bit CORE_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [dmAddB-1:0] c_ad,
  input  logic [N-1:0]      c_d,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [N-1:0]      c_q,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [dmAddB-1:0] d_ad,
  input  logic [N-1:0]      d_d,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [N-1:0]      d_q,
  output logic              dm_we,
  output logic              dm_re,
  output logic [dmAddB-1:0] dm_ad,
  output logic [N-1:0]      dm_d,
  input  logic [N-1:0]      dm_q,
  output logic [1:0]        dbg_state
);
  import the_pkg::*;

  arb_state_t        state;
  req_sel_t          sel;
  req_sel_t          rr_ptr;
  req_sel_t          pick_sel;
  logic              pick_valid;
  logic              pick_both;
  logic              lat_we;
  logic              lat_both;
  logic              win_we;
  logic [dmAddB-1:0] win_ad;
  logic [N-1:0]      win_d;

  dm_arb_pick #(
    .CORE_PRIO (CORE_PRIO)
  ) u_pick (
    .c_req       (c_req),
    .d_req       (d_req),
    .rr_ptr      (rr_ptr),
    .grant_valid (pick_valid),
    .both        (pick_both),
    .sel         (pick_sel)
  );

  always_comb begin
    win_we = c_we;
    win_ad = c_ad;
    win_d  = c_d;
    if (pick_sel == SEL_DMA) begin
      win_we = d_we;
      win_ad = d_ad;
      win_d  = d_d;
    end
  end

  // dm_ad/dm_d double as the request latch: they are loaded once at selection and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= SEL_CORE;
      rr_ptr   <= SEL_CORE;
      lat_we   <= 1'b0;
      lat_both <= 1'b0;
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_q      <= '0;
      d_q      <= '0;
      dm_we    <= 1'b0;
      dm_re    <= 1'b0;
      dm_ad    <= '0;
      dm_d     <= '0;
    end else begin
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      dm_we    <= 1'b0;
      dm_re    <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel      <= pick_sel;
            lat_both <= pick_both;
            lat_we   <= win_we;
            dm_ad    <= win_ad;
            dm_d     <= win_d;
            dm_we    <= win_we;
            dm_re    <= ~win_we;
            c_gnt    <= (pick_sel == SEL_CORE);
            d_gnt    <= (pick_sel == SEL_DMA);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_both) begin
            rr_ptr <= (sel == SEL_CORE) ? SEL_DMA : SEL_CORE;
          end
          state <= lat_we ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          if (sel == SEL_CORE) begin
            c_q      <= dm_q;
            c_rvalid <= 1'b1;
          end else begin
            d_q      <= dm_q;
            d_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a round-robin and a core-priority instance, each with its own RAM and
// a transaction-level model predicting every output on every cycle.
module tb_dm_arbiter;
  import the_pkg::*;

  localparam int AW    = dmAddB;
  localparam int DW    = N;
  localparam int DEPTH = 1 << AW;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          c_req[2], c_we[2], d_req[2], d_we[2];
  logic [AW-1:0] c_ad[2], d_ad[2], dm_ad[2];
  logic [DW-1:0] c_d[2], d_d[2], c_q[2], d_q[2], dm_d[2], dm_q[2];
  logic          c_gnt[2], d_gnt[2], c_rvalid[2], d_rvalid[2], dm_we[2], dm_re[2];
  logic [1:0]    dbg_state[2];
  logic [DW-1:0] mem[2][DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dm_arbiter #(
      .CORE_PRIO (g == 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .c_req     (c_req[g]),
      .c_we      (c_we[g]),
      .c_ad      (c_ad[g]),
      .c_d       (c_d[g]),
      .c_gnt     (c_gnt[g]),
      .c_rvalid  (c_rvalid[g]),
      .c_q       (c_q[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_ad      (d_ad[g]),
      .d_d       (d_d[g]),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_q       (d_q[g]),
      .dm_we     (dm_we[g]),
      .dm_re     (dm_re[g]),
      .dm_ad     (dm_ad[g]),
      .dm_d      (dm_d[g]),
      .dm_q      (dm_q[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // synchronous single-port RAM, one-cycle read latency, memoria[a] = a initially
  initial begin
    for (int i = 0; i < 2; i++) begin
      dm_q[i] = '0;
      for (int a = 0; a < DEPTH; a++) mem[i][a] = DW'(a);
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (dm_we[i]) mem[i][dm_ad[i]] <= dm_d[i];
        if (dm_re[i]) dm_q[i] <= mem[i][dm_ad[i]];
      end
    end
  end

  // transaction-level model: edge k picks a winner, its outputs show in cycle k, a write frees
  // the port at edge k+2, a read returns data in cycle k+2 and frees the port at edge k+3
  logic          e_c_gnt[2], e_d_gnt[2], e_c_rv[2], e_d_rv[2], e_we[2], e_re[2];
  logic [AW-1:0] e_ad[2];
  logic [DW-1:0] e_dd[2], e_c_q[2], e_d_q[2];
  logic [DW-1:0] mmem[2][DEPTH];
  longint        cyc;
  longint        next_sel[2], rd_at[2];
  bit            rd_dma[2], rr_dma[2];
  logic [DW-1:0] rd_data[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      e_c_gnt[i] = 0; e_d_gnt[i] = 0; e_c_rv[i] = 0; e_d_rv[i] = 0;
      e_we[i] = 0; e_re[i] = 0; e_ad[i] = '0; e_dd[i] = '0;
      e_c_q[i] = '0; e_d_q[i] = '0;
      next_sel[i] = 0; rd_at[i] = -1; rr_dma[i] = 0;
    end
  endtask

  task automatic model_step();
    bit            both, pick_dma, we;
    logic [AW-1:0] ad;
    for (int i = 0; i < 2; i++) begin
      e_c_gnt[i] = 0; e_d_gnt[i] = 0; e_c_rv[i] = 0; e_d_rv[i] = 0;
      e_we[i] = 0; e_re[i] = 0;
      if (rd_at[i] == cyc) begin
        if (rd_dma[i]) begin e_d_rv[i] = 1; e_d_q[i] = rd_data[i]; end
        else begin e_c_rv[i] = 1; e_c_q[i] = rd_data[i]; end
      end
      if (cyc >= next_sel[i] && (c_req[i] || d_req[i])) begin
        both     = c_req[i] && d_req[i];
        pick_dma = both ? ((i == 1) ? 1'b0 : rr_dma[i]) : d_req[i];
        if (both) rr_dma[i] = !pick_dma;
        we = pick_dma ? d_we[i] : c_we[i];
        ad = pick_dma ? d_ad[i] : c_ad[i];
        e_ad[i] = ad;
        e_dd[i] = pick_dma ? d_d[i] : c_d[i];
        e_we[i] = we;
        e_re[i] = !we;
        if (pick_dma) e_d_gnt[i] = 1; else e_c_gnt[i] = 1;
        if (we) begin
          mmem[i][ad] = e_dd[i];
          next_sel[i] = cyc + 2;
        end else begin
          rd_dma[i]   = pick_dma;
          rd_data[i]  = mmem[i][ad];
          rd_at[i]    = cyc + 2;
          next_sel[i] = cyc + 3;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < DEPTH; a++) mmem[i][a] = DW'(a);
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("c_gnt", i, c_gnt[i], e_c_gnt[i]);
      chk("d_gnt", i, d_gnt[i], e_d_gnt[i]);
      chk("c_rvalid", i, c_rvalid[i], e_c_rv[i]);
      chk("d_rvalid", i, d_rvalid[i], e_d_rv[i]);
      chk("c_q", i, c_q[i], e_c_q[i]);
      chk("d_q", i, d_q[i], e_d_q[i]);
      chk("dm_we", i, dm_we[i], e_we[i]);
      chk("dm_re", i, dm_re[i], e_re[i]);
      chk("dm_ad", i, dm_ad[i], e_ad[i]);
      chk("dm_d", i, dm_d[i], e_dd[i]);
      chk("we_re_exclusive", i, dm_we[i] & dm_re[i], 0);
    end
  end

  // driver tasks
  task automatic drive_core(input int i, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    c_req[i] = 1; c_we[i] = we; c_ad[i] = ad; c_d[i] = d;
  endtask

  task automatic drive_dma(input int i, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    d_req[i] = 1; d_we[i] = we; d_ad[i] = ad; d_d[i] = d;
  endtask

  task automatic random_agents();
    for (int i = 0; i < 2; i++) begin
      if (c_gnt[i]) begin
        if ($urandom_range(0, 2) == 0) c_req[i] = 0;
        else drive_core(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      end else if (c_req[i]) begin
        if ($urandom_range(0, 15) == 0) c_req[i] = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        drive_core(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      end
      if (d_gnt[i]) begin
        if ($urandom_range(0, 2) == 0) d_req[i] = 0;
        else drive_dma(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      end else if (d_req[i]) begin
        if ($urandom_range(0, 15) == 0) d_req[i] = 0;
      end else if ($urandom_range(0, 1) == 1) begin
        drive_dma(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      end
    end
  endtask

  logic [3:0] pat[2];
  int         gcnt[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      c_req[i] = 0; c_we[i] = 0; c_ad[i] = '0; c_d[i] = '0;
      d_req[i] = 0; d_we[i] = 0; d_ad[i] = '0; d_d[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_dm_ad", i, dm_ad[i], 0);
      chk("reset_c_gnt", i, c_gnt[i], 0);
      chk("reset_state", i, dbg_state[i], 0);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);

    // core write alone
    for (int i = 0; i < 2; i++) drive_core(i, 1, AW'(10), DW'(11));
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("wr_c_gnt", i, c_gnt[i], 1);
      chk("wr_dm_we", i, dm_we[i], 1);
      chk("wr_dm_ad", i, dm_ad[i], 10);
      chk("wr_dm_d", i, dm_d[i], 11);
      chk("wr_d_gnt", i, d_gnt[i], 0);
      c_req[i] = 0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("wr_gnt_one_cycle", i, c_gnt[i], 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("wr_memoria10", i, mem[i][10], 11);

    // DMA read alone
    for (int i = 0; i < 2; i++) drive_dma(i, 0, AW'(22), '0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rd_d_gnt", i, d_gnt[i], 1);
      chk("rd_dm_re", i, dm_re[i], 1);
      d_req[i] = 0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("rd_dm_re_one_cycle", i, dm_re[i], 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rd_d_rvalid", i, d_rvalid[i], 1);
      chk("rd_d_q", i, d_q[i], 22);
      chk("rd_c_rvalid", i, c_rvalid[i], 0);
    end
    repeat (2) @(negedge clk);

    // both requesting continuously, both writing
    for (int i = 0; i < 2; i++) begin
      drive_core(i, 1, AW'(1), DW'(100));
      drive_dma(i, 1, AW'(2), DW'(200));
      pat[i] = '0; gcnt[i] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (c_gnt[i] || d_gnt[i]) begin
          pat[i] = {pat[i][2:0], d_gnt[i]};
          gcnt[i]++;
        end
    end
    chk("cont_grants_rr", 0, gcnt[0], 4);
    chk("cont_grants_prio", 1, gcnt[1], 4);
    chk("cont_order_rr", 0, pat[0], 4'b0101);
    chk("cont_order_prio", 1, pat[1], 4'b0000);
    for (int i = 0; i < 2; i++) c_req[i] = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("cont_dma_after_core_drop", i, d_gnt[i], 1);
      d_req[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("cont_memoria2", i, mem[i][2], 200);

    // read after write, same address
    for (int i = 0; i < 2; i++) drive_core(i, 1, AW'(5), DW'(32'hA5));
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("raw_wr_gnt", i, c_gnt[i], 1);
      c_we[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("raw_rd_gnt", i, c_gnt[i], 1);
      chk("raw_rd_ad", i, dm_ad[i], 5);
      c_req[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("raw_c_rvalid", i, c_rvalid[i], 1);
      chk("raw_c_q", i, c_q[i], 32'hA5);
    end
    @(negedge clk);

    // asynchronous reset while in RD_WAIT
    for (int i = 0; i < 2; i++) drive_dma(i, 0, AW'(30), '0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) d_req[i] = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_dm_ad", i, dm_ad[i], 0);
      chk("arst_c_q", i, c_q[i], 0);
      chk("arst_d_q", i, d_q[i], 0);
      chk("arst_state", i, dbg_state[i], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("arst_no_rvalid", i, d_rvalid[i], 0);
    end
    for (int i = 0; i < 2; i++) drive_core(i, 0, AW'(22), '0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("arst_next_gnt", i, c_gnt[i], 1);
      c_req[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("arst_next_c_q", i, c_q[i], 22);

    // randomized traffic against the model
    repeat (1200) begin
      @(negedge clk);
      random_agents();
    end
    for (int i = 0; i < 2; i++) begin
      c_req[i] = 0;
      d_req[i] = 0;
    end
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
